// File: rtl/oled_text_scheduler.sv
// Purpose: renders one line of up to MAX_GLYPHS glyphs as an OLED byte stream (page/column commands + glyph columns).
// Latency: busy the cycle after start; 3 command bytes per row, then one data byte every 3 cycles at best.
// Backpressure: every byte is held on out_valid/out_dc/out_byte until out_valid&out_ready; no internal buffering.
//
// Ports:
//   sys_clk, rst            clock, synchronous active-high reset
//   start, start_page,
//   start_col, glyph_cnt    line request (latched when idle)
//   glyph_idx / glyph_code  slot fetched from the host / its code (combinational reply)
//   font_sel, font_row,
//   index / font_data       glyph ROM address / registered ROM byte (1-cycle latency)
//   out_valid, out_dc,
//   out_byte / out_ready    byte stream to the OLED transmitter
//   busy, done              line in progress / one-cycle completion pulse
module oled_text_scheduler #(
  parameter int          MAX_GLYPHS = 16,
  parameter logic [63:0] WIDE_MASK  = 64'h0000_0000_0000_0BF0,
  parameter int          MAX_CODE   = 14
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [2:0]                    start_page,
  input  logic [6:0]                    start_col,
  input  logic [4:0]                    glyph_cnt,
  output logic [$clog2(MAX_GLYPHS)-1:0] glyph_idx,
  input  logic [5:0]                    glyph_code,
  output logic [5:0]                    font_sel,
  output logic                          font_row,
  output logic [8:0]                    index,
  input  logic [7:0]                    font_data,
  output logic                          out_valid,
  output logic                          out_dc,
  output logic [7:0]                    out_byte,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W = $clog2(MAX_GLYPHS);
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WAIT,
    S_SEND,
    S_FINISH
  } state_t;

  state_t           state;
  logic [2:0]       page_q;
  logic [6:0]       col0_q;
  logic [6:0]       col_q;
  logic [4:0]       cnt_q;
  logic             row_q;
  logic [3:0]       cig_q;      // column within the current glyph
  logic [1:0]       cmd_cnt;
  logic [5:0]       code_q;
  logic             wide_q;
  logic [IDX_W-1:0] glyph_idx_q;
  logic             out_valid_q;
  logic             out_dc_q;
  logic [7:0]       out_byte_q;
  logic             busy_q;
  logic             done_q;

  logic             glyph_end;
  logic             last_glyph;
  logic             row_end;

  // Command byte encodings for the SSD1306-style address set.
  function automatic logic [7:0] page_cmd(input logic [2:0] p);
    return {5'b10110, p};
  endfunction

  function automatic logic [7:0] col_lo_cmd(input logic [6:0] c);
    return {4'h0, c[3:0]};
  endfunction

  function automatic logic [7:0] col_hi_cmd(input logic [6:0] c);
    return {5'b00010, c[6:4]};
  endfunction

  // The ROM must see the host's code during the ADDR cycle itself so its
  // registered byte is ready for capture at the end of WAIT; outside ADDR the
  // address holds the code of the glyph being sent.
  assign font_sel  = (state == S_ADDR) ? glyph_code : code_q;
  assign font_row  = row_q;
  assign index     = {5'd0, cig_q};
  assign glyph_idx = glyph_idx_q;
  assign out_valid = out_valid_q;
  assign out_dc    = out_dc_q;
  assign out_byte  = out_byte_q;
  assign busy      = busy_q;
  assign done      = done_q;

  assign glyph_end  = wide_q ? (cig_q == 4'd15) : (cig_q == 4'd7);
  assign last_glyph = ((5'(glyph_idx_q) + 5'd1) == cnt_q);
  // Column 127 clips the row: no wrap back to column 0.
  assign row_end    = (col_q == 7'd127) || (glyph_end && last_glyph);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      page_q      <= '0;
      col0_q      <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      row_q       <= 1'b0;
      cig_q       <= '0;
      cmd_cnt     <= '0;
      code_q      <= '0;
      wide_q      <= 1'b0;
      glyph_idx_q <= '0;
      out_valid_q <= 1'b0;
      out_dc_q    <= 1'b0;
      out_byte_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // done_q marks the completion cycle; a start there is dropped.
          if (start && !done_q) begin
            page_q      <= start_page;
            col0_q      <= start_col;
            col_q       <= start_col;
            cnt_q       <= (glyph_cnt > 5'(MAX_GLYPHS)) ? 5'(MAX_GLYPHS) : glyph_cnt;
            row_q       <= 1'b0;
            cig_q       <= '0;
            cmd_cnt     <= '0;
            glyph_idx_q <= '0;
            busy_q      <= 1'b1;
            if (glyph_cnt == 5'd0) begin
              state <= S_FINISH;
            end else begin
              out_valid_q <= 1'b1;
              out_dc_q    <= 1'b0;
              out_byte_q  <= page_cmd(start_page);
              state       <= S_CMD;
            end
          end
        end

        // out_valid is high for the whole of CMD; one byte per accepted cycle.
        S_CMD: begin
          if (out_ready) begin
            case (cmd_cnt)
              2'd0: begin
                out_byte_q <= col_lo_cmd(col0_q);
                cmd_cnt    <= 2'd1;
              end
              2'd1: begin
                out_byte_q <= col_hi_cmd(col0_q);
                cmd_cnt    <= 2'd2;
              end
              default: begin
                out_valid_q <= 1'b0;
                state       <= S_ADDR;
              end
            endcase
          end
        end

        S_ADDR: begin
          code_q <= glyph_code;
          wide_q <= WIDE_MASK[glyph_code];
          state  <= S_WAIT;
        end

        // font_data now reflects the address driven in ADDR.
        S_WAIT: begin
          out_byte_q  <= (code_q > 6'(MAX_CODE)) ? 8'h00 : font_data;
          out_dc_q    <= 1'b1;
          out_valid_q <= 1'b1;
          state       <= S_SEND;
        end

        S_SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            col_q       <= col_q + 7'd1;
            if (row_end) begin
              if (!row_q) begin
                // Second half-row restarts at the first glyph and column,
                // one page lower (page 7 wraps to 0).
                row_q       <= 1'b1;
                glyph_idx_q <= '0;
                cig_q       <= '0;
                col_q       <= col0_q;
                cmd_cnt     <= '0;
                out_valid_q <= 1'b1;
                out_dc_q    <= 1'b0;
                out_byte_q  <= page_cmd(page_q + 3'd1);
                state       <= S_CMD;
              end else begin
                state <= S_FINISH;
              end
            end else begin
              if (glyph_end) begin
                glyph_idx_q <= glyph_idx_q + IDX_ONE;
                cig_q       <= '0;
              end else begin
                cig_q <= cig_q + 4'd1;
              end
              state <= S_ADDR;
            end
          end
        end

        S_FINISH: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_text_scheduler.sv
// Purpose: self-checking bench for oled_text_scheduler (vector table + scoreboard + corner sequences).
// Latency: stimulus waits are bounded; expiry is reported as a failed comparison.
// Backpressure: out_ready is driven always-high, pseudo-random, or stalled on data bytes.
module tb_oled_text_scheduler;

  localparam logic [63:0] TB_WIDE = 64'h0000_0000_0000_0BF0;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  start_page = '0;
  logic [6:0]  start_col = '0;
  logic [4:0]  glyph_cnt = '0;
  logic [3:0]  glyph_idx;
  logic [5:0]  glyph_code;
  logic [5:0]  font_sel;
  logic        font_row;
  logic [8:0]  index;
  logic [7:0]  font_data = '0;
  logic        out_valid;
  logic        out_dc;
  logic [7:0]  out_byte;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [15:0][5:0] codes_cur = '0;
  int               ready_mode = 0;   // 0 always, 1 random, 2 stall data bytes
  int               checks = 0;
  int               failures = 0;
  int               done_cnt = 0;
  logic [8:0]       exp_q[$];
  logic [8:0]       got_q[$];

  typedef struct {
    logic [2:0]       page;
    logic [6:0]       col;
    logic [4:0]       cnt;
    logic [15:0][5:0] codes;
    int               mode;
    bit               poke;       // pulse start while busy
    int               exp_bytes;
    logic [7:0]       exp_row1_page;
  } vec_t;

  vec_t vecs[8];

  oled_text_scheduler dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .start     (start),
    .start_page(start_page),
    .start_col (start_col),
    .glyph_cnt (glyph_cnt),
    .glyph_idx (glyph_idx),
    .glyph_code(glyph_code),
    .font_sel  (font_sel),
    .font_row  (font_row),
    .index     (index),
    .font_data (font_data),
    .out_valid (out_valid),
    .out_dc    (out_dc),
    .out_byte  (out_byte),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 sys_clk = ~sys_clk;

  assign glyph_code = codes_cur[glyph_idx];

  // Glyph ROM model: code 0 holds the reference glyph, others a distinct pattern.
  function automatic logic [7:0] rom_fn(input logic [5:0] s, input logic r, input logic [3:0] i);
    logic [63:0] top;
    logic [63:0] bot;
    top = 64'h08F8_8888_E808_1000;
    bot = 64'h203F_2000_0300_0000;
    if (s == 6'd0) return r ? bot[63-8*i[2:0] -: 8] : top[63-8*i[2:0] -: 8];
    return {s[3:0], i} ^ (r ? 8'h5A : 8'h00);
  endfunction

  always @(posedge sys_clk)
    font_data <= (index[8:4] != 5'd0) ? 8'hEE : rom_fn(font_sel, font_row, index[3:0]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference byte stream for one line, built from the behavioural description.
  task automatic push_expected(input logic [2:0] pg, input logic [6:0] c0, input logic [4:0] n,
                               input logic [15:0][5:0] cds);
    int cnt;
    cnt = (n > 5'd16) ? 16 : int'(n);
    if (cnt == 0) return;
    for (int r = 0; r < 2; r++) begin
      int  col;
      bit  stop;
      logic [2:0] p;
      p = pg + 3'(r);
      exp_q.push_back({1'b0, 5'b10110, p});
      exp_q.push_back({1'b0, 4'h0, c0[3:0]});
      exp_q.push_back({1'b0, 5'b00010, c0[6:4]});
      col  = int'(c0);
      stop = 0;
      for (int g = 0; g < cnt && !stop; g++) begin
        int w;
        w = TB_WIDE[cds[g]] ? 16 : 8;
        for (int k = 0; k < w && !stop; k++) begin
          exp_q.push_back({1'b1, (cds[g] > 6'd14) ? 8'h00 : rom_fn(cds[g], r[0], 4'(k))});
          if (col == 127) stop = 1;
          col++;
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge sys_clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = !(out_valid && out_dc);
        default: out_ready = 1'b0;
      endcase
    end
  endtask

  task automatic monitor();
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = '0;
    logic       prev_dc = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (out_valid) check("valid_without_busy", busy, 1);
        if (prev_stall) check("held_byte", {out_valid, out_dc, out_byte}, {1'b1, prev_dc, prev_byte});
        if (out_valid && out_ready) begin
          got_q.push_back({out_dc, out_byte});
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_byte: got dc=%0b 0x%02h expected none", out_dc, out_byte);
          end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if ({out_dc, out_byte} !== e) begin
              failures++;
              $display("FAIL stream byte %0d: got dc=%0b 0x%02h expected dc=%0b 0x%02h",
                       got_q.size() - 1, out_dc, out_byte, e[8], e[7:0]);
            end
          end
        end
        if (done) done_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_byte  = out_byte;
        prev_dc    = out_dc;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {glyph_idx, font_sel, font_row, index, out_valid, out_dc, out_byte, busy, done}, 0);
  endtask

  task automatic set_vec(input int i, input logic [2:0] pg, input logic [6:0] c, input logic [4:0] n,
                         input int mode, input bit poke, input int nb, input logic [7:0] p1);
    vecs[i].page = pg;  vecs[i].col = c;  vecs[i].cnt = n;  vecs[i].codes = '0;
    vecs[i].mode = mode; vecs[i].poke = poke; vecs[i].exp_bytes = nb; vecs[i].exp_row1_page = p1;
  endtask

  task automatic run_vec(input int v);
    int  d0;
    bit  seen;
    logic [8:0] r1;
    codes_cur  = vecs[v].codes;
    ready_mode = vecs[v].mode;
    got_q.delete();
    exp_q.delete();
    push_expected(vecs[v].page, vecs[v].col, vecs[v].cnt, vecs[v].codes);
    d0 = done_cnt;
    @(posedge sys_clk); #1;
    start = 1'b1; start_page = vecs[v].page; start_col = vecs[v].col; glyph_cnt = vecs[v].cnt;
    @(posedge sys_clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge sys_clk);
      if (vecs[v].poke && i == 25) begin
        start = 1'b1; start_page = 3'd5; start_col = 7'd3; glyph_cnt = 5'd0;
      end
      if (vecs[v].poke && i == 26) start = 1'b0;
      if (done) begin
        seen = 1;
        check($sformatf("v%0d busy_at_done", v), busy, 0);
        break;
      end
    end
    if (!seen) check($sformatf("v%0d done_timeout", v), 0, 1);
    repeat (3) @(negedge sys_clk);
    check($sformatf("v%0d done_pulses", v), done_cnt - d0, 1);
    check($sformatf("v%0d byte_count", v), got_q.size(), vecs[v].exp_bytes);
    r1 = (got_q.size() > vecs[v].exp_bytes / 2) ? got_q[vecs[v].exp_bytes / 2] : 9'h1FF;
    check($sformatf("v%0d row1_page_cmd", v), r1, {1'b0, vecs[v].exp_row1_page});
    check($sformatf("v%0d leftover_expected", v), exp_q.size(), 0);
  endtask

  initial begin
    bit  seen;
    int  d0;

    set_vec(0, 3'd2, 7'd0,   5'd1,  0, 0, 22,  8'hB3);
    set_vec(1, 3'd0, 7'h25,  5'd2,  0, 1, 54,  8'hB1);
    vecs[1].codes[0] = 6'd6;  vecs[1].codes[1] = 6'd10;
    set_vec(2, 3'd7, 7'd10,  5'd1,  0, 0, 22,  8'hB0);
    vecs[2].codes[0] = 6'd1;
    set_vec(3, 3'd3, 7'd124, 5'd1,  0, 0, 14,  8'hB4);
    vecs[3].codes[0] = 6'd4;
    set_vec(4, 3'd2, 7'd0,   5'd1,  1, 0, 22,  8'hB3);
    set_vec(5, 3'd1, 7'd8,   5'd1,  0, 0, 22,  8'hB2);
    vecs[5].codes[0] = 6'd20;
    set_vec(6, 3'd5, 7'd0,   5'd20, 0, 0, 262, 8'hB6);
    set_vec(7, 3'd6, 7'd100, 5'd3,  1, 1, 62,  8'hB7);
    vecs[7].codes[0] = 6'd6;  vecs[7].codes[1] = 6'd10;  vecs[7].codes[2] = 6'd3;

    fork
      ready_driver();
      monitor();
    join_none

    repeat (3) @(negedge sys_clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    @(negedge sys_clk);
    check_all_zero("idle_after_reset");

    for (int v = 0; v < 8; v++) run_vec(v);

    // Empty line: busy for one cycle, then done with busy low; a start in
    // the done cycle must be dropped.
    ready_mode = 0;
    got_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    @(posedge sys_clk); #1;
    start = 1'b1; start_page = 3'd1; start_col = 7'd0; glyph_cnt = 5'd0;
    @(posedge sys_clk); #1;
    start = 1'b0;
    @(negedge sys_clk);
    check("cnt0 busy_then", {busy, done}, 2'b10);
    @(negedge sys_clk);
    check("cnt0 done_cycle", {busy, done}, 2'b01);
    start = 1'b1; glyph_cnt = 5'd1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    @(negedge sys_clk);
    check("start_in_done_ignored", {busy, done}, 2'b00);
    repeat (10) @(negedge sys_clk);
    check("cnt0 no_bytes", got_q.size(), 0);
    check("cnt0 single_done", done_cnt - d0, 1);

    // Reset while a data byte is stalled in SEND.
    ready_mode = 2;
    codes_cur  = '0;
    got_q.delete();
    exp_q.delete();
    push_expected(3'd4, 7'd16, 5'd1, codes_cur);
    @(posedge sys_clk); #1;
    start = 1'b1; start_page = 3'd4; start_col = 7'd16; glyph_cnt = 5'd1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (out_valid && out_dc) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("send_stall_timeout", 0, 1);
    repeat (2) @(negedge sys_clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge sys_clk);
    check_all_zero("reset_mid_send");
    rst = 1'b0;
    ready_mode = 0;
    repeat (30) @(negedge sys_clk);
    check("after_abort_bytes", got_q.size(), 3);
    check("after_abort_idle", {busy, out_valid}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
